// File: rtl/muldiv_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
// The unit itself connects through the slave modport; the requester uses master.
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             i_start;
    logic [2:0]       i_op;
    logic [WIDTH-1:0] i_a;
    logic [WIDTH-1:0] i_b;
    logic             o_busy;
    logic             o_done;
    logic             o_div_by_zero;
    logic [WIDTH-1:0] o_hi;
    logic [WIDTH-1:0] o_lo;

    modport master (
        output i_start, i_op, i_a, i_b,
        input  o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );

    modport slave (
        input  i_start, i_op, i_a, i_b,
        output o_busy, o_done, o_div_by_zero, o_hi, o_lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit with private HI/LO registers.
// Signed operations run on magnitudes; signs are reapplied in the FIX state.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    localparam logic [WIDTH-1:0]   ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE2  = {{(2*WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0]   ZERO  = '0;

    logic [1:0]         r_state;
    logic [CW-1:0]      r_cnt;
    logic               r_isDiv;
    logic               r_negLo;
    logic               r_negHi;
    logic               r_bZero;
    logic [WIDTH-1:0]   r_aOrig;
    logic [WIDTH-1:0]   r_opnd;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;
    logic               r_dbz;

    logic               w_accept;
    logic               w_isMulDiv;
    logic               w_signed;
    logic [WIDTH-1:0]   w_aMag;
    logic [WIDTH-1:0]   w_bMag;
    logic [WIDTH:0]     w_mulSum;
    logic [2*WIDTH-1:0] w_mulNext;
    logic [WIDTH:0]     w_divShift;
    logic               w_divOk;
    logic [WIDTH-1:0]   w_divDiff;
    logic [2*WIDTH-1:0] w_divNext;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_fixHi;
    logic [WIDTH-1:0]   w_fixLo;

    // Requests are only honoured while idle; ops 000-011 start an iteration.
    assign w_accept   = bus.i_start && (r_state == S_IDLE);
    assign w_isMulDiv = ~bus.i_op[2];
    assign w_signed   = ~bus.i_op[0];
    assign w_aMag     = (w_signed && bus.i_a[WIDTH-1]) ? (~bus.i_a + ONE) : bus.i_a;
    assign w_bMag     = (w_signed && bus.i_b[WIDTH-1]) ? (~bus.i_b + ONE) : bus.i_b;

    // Multiply step: add multiplicand into the upper half when the low bit is set, then shift right.
    assign w_mulSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
    assign w_mulNext = {w_mulSum, r_acc[WIDTH-1:1]};

    // Divide step: shift the next dividend bit into the remainder and subtract if it fits.
    // The true difference is always below 2^WIDTH, so the low WIDTH bits suffice.
    assign w_divShift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_divOk    = (w_divShift >= {1'b0, r_opnd});
    assign w_divDiff  = w_divShift[WIDTH-1:0] - r_opnd;
    assign w_divNext  = {(w_divOk ? w_divDiff : w_divShift[WIDTH-1:0]), r_acc[WIDTH-2:0], w_divOk};

    // Sign correction and result selection written into HI/LO at the FIX edge.
    always_comb begin
        w_prod  = r_negLo ? (~r_acc + ONE2) : r_acc;
        w_quot  = r_negLo ? (~r_acc[WIDTH-1:0] + ONE) : r_acc[WIDTH-1:0];
        w_rem   = r_negHi ? (~r_acc[2*WIDTH-1:WIDTH] + ONE) : r_acc[2*WIDTH-1:WIDTH];
        w_fixHi = w_prod[2*WIDTH-1:WIDTH];
        w_fixLo = w_prod[WIDTH-1:0];
        if (r_isDiv) begin
            if (r_bZero) begin
                w_fixHi = r_aOrig;
                w_fixLo = '1;
            end else begin
                w_fixHi = w_rem;
                w_fixLo = w_quot;
            end
        end
    end

    // Control FSM and iteration datapath: latch magnitudes, iterate WIDTH times, then fix up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_isDiv <= 1'b0;
            r_negLo <= 1'b0;
            r_negHi <= 1'b0;
            r_bZero <= 1'b0;
            r_aOrig <= '0;
            r_opnd  <= '0;
            r_acc   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_isMulDiv) begin
                        r_state <= S_RUN;
                        r_cnt   <= '0;
                        r_isDiv <= bus.i_op[1];
                        r_negLo <= w_signed & (bus.i_a[WIDTH-1] ^ bus.i_b[WIDTH-1]);
                        r_negHi <= w_signed & bus.i_a[WIDTH-1];
                        r_bZero <= (bus.i_b == ZERO);
                        r_aOrig <= bus.i_a;
                        if (bus.i_op[1]) begin
                            r_acc  <= {ZERO, w_aMag};
                            r_opnd <= w_bMag;
                        end else begin
                            r_acc  <= {ZERO, w_bMag};
                            r_opnd <= w_aMag;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= r_isDiv ? w_divNext : w_mulNext;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // HI/LO change only on a finished operation or an accepted MTHI/MTLO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi <= '0;
            r_lo <= '0;
        end else if (r_state == S_FIX) begin
            r_hi <= w_fixHi;
            r_lo <= w_fixLo;
        end else if (w_accept && (bus.i_op == 3'b100)) begin
            r_hi <= bus.i_a;
        end else if (w_accept && (bus.i_op == 3'b101)) begin
            r_lo <= bus.i_a;
        end
    end

    // Done pulses for the cycle after FIX; the divide-by-zero flag holds until the next accepted request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
            r_dbz  <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIX);
            if (r_state == S_FIX) begin
                r_dbz <= r_isDiv & r_bZero;
            end else if (w_accept && (bus.i_op <= 3'd5)) begin
                r_dbz <= 1'b0;
            end
        end
    end

    assign bus.o_busy        = (r_state != S_IDLE);
    assign bus.o_done        = r_done;
    assign bus.o_div_by_zero = r_dbz;
    assign bus.o_hi          = r_hi;
    assign bus.o_lo          = r_lo;
endmodule
